// File: rtl/timestamp_multi_core.sv
`default_nettype none
// ============================================================================
//  Module      : timestamp_multi_core
//  Description : Multi-channel edge timestamper. Captures a 64-bit time base
//                on qualified edges of up to eight asynchronous inputs and
//                serialises each event into three 32-bit words in a
//                first-word-fall-through FIFO. Configured over an 8-bit
//                register bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module timestamp_multi_core #(
    parameter int          ABUSWIDTH  = 16,
    parameter logic [3:0]  IDENTIFIER = 4'b0001,
    parameter int          CHANNELS   = 4,
    parameter int          FIFO_DEPTH = 64,
    parameter logic [7:0]  VERSION    = 8'd1
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic [CHANNELS-1:0]  DI,
    input  logic [63:0]          EXT_TIMESTAMP,
    input  logic                 EXT_ENABLE,
    output logic [63:0]          TIMESTAMP_OUT,
    input  logic                 FIFO_READ,
    output logic                 FIFO_EMPTY,
    output logic [31:0]          FIFO_DATA
);

    localparam int C_AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_W0   = 2'd1;
    localparam logic [1:0] ST_W1   = 2'd2;
    localparam logic [1:0] ST_W2   = 2'd3;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                soft_rst;
    logic [7:0]          conf_q;
    logic [CHANNELS-1:0] chen_q;
    logic [CHANNELS-1:0] rise_en_q;
    logic [CHANNELS-1:0] fall_en_q;
    logic [7:0]          lost_q;
    logic [7:0]          bus_dout_q;
    logic [63:0]         snap_q;
    logic [63:0]         rd_shift;
    logic [7:0]          rd_mux;
    logic [63:0]         cnt_q;

    logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q;
    logic [CHANNELS-1:0] edge_r_q, edge_f_q;
    logic [CHANNELS-1:0] qual, clr, lost_ev;
    logic                gate_ok;
    logic [CHANNELS-1:0] pend_q;
    logic [CHANNELS-1:0] rise_flag_q;
    logic [63:0]         ts_q [CHANNELS];
    logic [3:0]          lost_inc;
    logic [8:0]          lost_sum;

    logic                any_pend;
    logic [2:0]          sel;
    logic [63:0]         sel_ts;
    logic                sel_rise;

    logic [1:0]          state_q, state_d;
    logic                take;
    logic                wr_ok;
    logic                fifo_wr;
    logic [31:0]         fifo_wdata;
    logic [63:0]         hold_ts_q;
    logic                hold_rise_q;
    logic [2:0]          hold_ch_q;

    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [C_AW-1:0]     wptr_q, rptr_q;
    logic [C_AW:0]       count_q;
    logic                fifo_full;
    logic                rd_en;

    assign soft_rst      = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
    assign TIMESTAMP_OUT = conf_q[1] ? EXT_TIMESTAMP : cnt_q;
    assign BUS_DATA_OUT  = bus_dout_q;

    // ------------------------------------------------------------------
    // Register bus
    // ------------------------------------------------------------------
    // Configuration registers; a soft reset leaves them untouched.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            conf_q    <= '0;
            chen_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (BUS_WR) begin
            if (BUS_ADD == ABUSWIDTH'(1)) conf_q    <= BUS_DATA_IN;
            if (BUS_ADD == ABUSWIDTH'(2)) chen_q    <= BUS_DATA_IN[CHANNELS-1:0];
            if (BUS_ADD == ABUSWIDTH'(3)) rise_en_q <= BUS_DATA_IN[CHANNELS-1:0];
            if (BUS_ADD == ABUSWIDTH'(4)) fall_en_q <= BUS_DATA_IN[CHANNELS-1:0];
        end
    end

    // Read-data select; address 8 reads live, 9..15 read the snapshot.
    always_comb begin
        rd_shift = snap_q >> {BUS_ADD[2:0], 3'b000};
        rd_mux   = 8'h00;
        if (BUS_ADD == ABUSWIDTH'(0))      rd_mux = VERSION;
        else if (BUS_ADD == ABUSWIDTH'(1)) rd_mux = conf_q;
        else if (BUS_ADD == ABUSWIDTH'(2)) rd_mux = 8'(chen_q);
        else if (BUS_ADD == ABUSWIDTH'(3)) rd_mux = 8'(rise_en_q);
        else if (BUS_ADD == ABUSWIDTH'(4)) rd_mux = 8'(fall_en_q);
        else if (BUS_ADD == ABUSWIDTH'(5)) rd_mux = lost_q;
        else if (BUS_ADD == ABUSWIDTH'(8)) rd_mux = TIMESTAMP_OUT[7:0];
        else if (BUS_ADD[ABUSWIDTH-1:3] == (ABUSWIDTH-3)'(1)) rd_mux = rd_shift[7:0];
    end

    // Registered read data and the 64-bit snapshot taken on a read of address 8.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            bus_dout_q <= '0;
            snap_q     <= '0;
        end else if (BUS_RD) begin
            bus_dout_q <= rd_mux;
            if (BUS_ADD == ABUSWIDTH'(8)) snap_q <= TIMESTAMP_OUT;
        end
    end

    // Free-running internal time base.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N)    cnt_q <= '0;
        else if (soft_rst) cnt_q <= '0;
        else               cnt_q <= cnt_q + 64'd1;
    end

    // ------------------------------------------------------------------
    // Per-channel synchroniser, edge detection and capture
    // ------------------------------------------------------------------
    // Two-flop synchroniser plus a third stage for registered edge flags.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
            edge_r_q <= '0;
            edge_f_q <= '0;
        end else begin
            sync1_q  <= DI;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            edge_r_q <= sync2_q & ~sync3_q;
            edge_f_q <= ~sync2_q & sync3_q;
        end
    end

    // Edge qualification and lost-edge detection per channel.
    always_comb begin
        gate_ok = !conf_q[2] || EXT_ENABLE;
        qual    = '0;
        clr     = '0;
        lost_ev = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            qual[i]    = conf_q[0] && chen_q[i] && gate_ok &&
                         ((edge_r_q[i] && rise_en_q[i]) || (edge_f_q[i] && fall_en_q[i]));
            clr[i]     = take && (sel == 3'(i));
            lost_ev[i] = qual[i] && pend_q[i] && !clr[i];
        end
    end

    // Capture slots: a new edge overwrites only a free or just-released slot.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            pend_q      <= '0;
            rise_flag_q <= '0;
            for (int i = 0; i < CHANNELS; i++) ts_q[i] <= '0;
        end else if (soft_rst) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (qual[i] && (!pend_q[i] || clr[i])) begin
                    ts_q[i]        <= TIMESTAMP_OUT;
                    rise_flag_q[i] <= edge_r_q[i];
                    pend_q[i]      <= 1'b1;
                end else if (clr[i]) begin
                    pend_q[i]      <= 1'b0;
                end
            end
        end
    end

    // Count dropped edges across all channels in this cycle.
    always_comb begin
        lost_inc = '0;
        for (int i = 0; i < CHANNELS; i++) lost_inc = lost_inc + 4'(lost_ev[i]);
        lost_sum = {1'b0, lost_q} + {5'd0, lost_inc};
    end

    // Saturating lost-edge counter.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N)       lost_q <= '0;
        else if (soft_rst)    lost_q <= '0;
        else if (lost_sum[8]) lost_q <= 8'hFF;
        else                  lost_q <= lost_sum[7:0];
    end

    // ------------------------------------------------------------------
    // Arbiter / serialiser
    // ------------------------------------------------------------------
    // Lowest-index pending channel wins.
    always_comb begin
        any_pend = |pend_q;
        sel      = '0;
        sel_ts   = '0;
        sel_rise = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel      = 3'(i);
                sel_ts   = ts_q[i];
                sel_rise = rise_flag_q[i];
            end
        end
    end

    // A write can proceed if there is room or a pop frees a slot this cycle.
    assign wr_ok = !fifo_full || FIFO_READ;

    // FSM state register.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N)    state_q <= ST_IDLE;
        else if (soft_rst) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_pend) state_d = ST_W0;
            ST_W0:   if (wr_ok)    state_d = ST_W1;
            ST_W1:   if (wr_ok)    state_d = ST_W2;
            ST_W2:   if (wr_ok)    state_d = any_pend ? ST_W0 : ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO write word and the take strobe that releases a slot.
    always_comb begin
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        take       = 1'b0;
        case (state_q)
            ST_IDLE: take = any_pend;
            ST_W0: begin
                fifo_wr    = wr_ok;
                fifo_wdata = {IDENTIFIER, 2'd0, 2'b00, hold_rise_q, hold_ch_q,
                              hold_ts_q[63:48], 4'b0000};
            end
            ST_W1: begin
                fifo_wr    = wr_ok;
                fifo_wdata = {IDENTIFIER, 2'd1, 2'b00, hold_ts_q[47:24]};
            end
            ST_W2: begin
                fifo_wr    = wr_ok;
                fifo_wdata = {IDENTIFIER, 2'd2, 2'b00, hold_ts_q[23:0]};
                take       = wr_ok && any_pend;
            end
            default: ;
        endcase
    end

    // Hold the selected capture while its three words are emitted.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            hold_ts_q   <= '0;
            hold_rise_q <= 1'b0;
            hold_ch_q   <= '0;
        end else if (take) begin
            hold_ts_q   <= sel_ts;
            hold_rise_q <= sel_rise;
            hold_ch_q   <= sel;
        end
    end

    // ------------------------------------------------------------------
    // FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign fifo_full  = (count_q == (C_AW+1)'(FIFO_DEPTH));
    assign FIFO_EMPTY = (count_q == '0);
    assign rd_en      = FIFO_READ && !FIFO_EMPTY;
    assign FIFO_DATA  = FIFO_EMPTY ? 32'd0 : mem_q[rptr_q];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge BUS_CLK) begin
        if (fifo_wr) mem_q[wptr_q] <= fifo_wdata;
    end

    // Pointers and occupancy.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (soft_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (fifo_wr) wptr_q <= wptr_q + 1'b1;
            if (rd_en)   rptr_q <= rptr_q + 1'b1;
            case ({fifo_wr, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/timestamp_multi_core.md
# timestamp_multi_core

Multi-channel successor of the single-input timestamp core. Captures a 64-bit timestamp on configurable edges of up to eight asynchronous inputs, queues each event as three 32-bit words in an internal FIFO, and is read by the readout arbiter via FIFO_READ/FIFO_EMPTY/FIFO_DATA. It is configured through the 8-bit basil register bus and runs on a single clock domain.

## Interface
- ABUSWIDTH, 16: register bus address width.
- IDENTIFIER, 4'b0001: tag placed in FIFO_DATA[31:28].
- CHANNELS, 4: number of DI inputs, 1..8.
- FIFO_DEPTH, 64: FIFO depth in 32-bit words; power of 2, at least 4.
- VERSION, 8'd1: value read at address 0.
- BUS_CLK  in  1  sole clock for bus, counter, capture and FIFO.
- BUS_RST_N  in  1  asynchronous, active-low reset.
- BUS_ADD  in  ABUSWIDTH  register address, already offset to 0.
- BUS_DATA_IN  in  8  write data.
- BUS_DATA_OUT  out  8  read data.
- BUS_RD / BUS_WR  in  1  single-cycle read and write strobes.
- DI  in  CHANNELS  asynchronous event inputs.
- EXT_TIMESTAMP  in  64  external time base, synchronous to BUS_CLK.
- EXT_ENABLE  in  1  external capture gate.
- TIMESTAMP_OUT  out  64  selected time base.
- FIFO_READ  in  1  pop strobe.
- FIFO_EMPTY  out  1  FIFO holds no words.
- FIFO_DATA  out  32  head word, first-word-fall-through.

## Operation
- Registers (all reset to 0):
  - 0: write any value = soft reset. Clears the counter, pending flags, FIFO, LOST and the FSM; configuration is kept. Read returns VERSION.
  - 1 CONF: bit0 ENABLE; bit1 USE_EXT (TIMESTAMP_OUT = EXT_TIMESTAMP, otherwise the internal counter); bit2 GATE (capture only while EXT_ENABLE=1).
  - 2 CH_EN mask. 3 RISE mask. 4 FALL mask. Bits at or above CHANNELS are read back as 0.
  - 5 LOST: read-only, saturating 8-bit count of dropped edges.
  - 8..15: TIMESTAMP_OUT bytes, LSB first. Reading address 8 snapshots all 64 bits; addresses 9..15 return that snapshot.
- Internal counter: 64-bit, increments every cycle after reset regardless of ENABLE. Wraps from 2^64-1 to 0.
- Per channel:
  - 2-FF synchroniser, then edge detector.
  - A qualified edge requires ENABLE, CH_EN[i], the matching RISE[i]/FALL[i] bit, and (GATE=0 or EXT_ENABLE=1).
  - On a qualified edge: load ts[i] with TIMESTAMP_OUT, edge[i] (1 = rising), and set pend[i].
  - If pend[i] is already set and not being cleared in that cycle: LOST++ and the old capture is kept.
  - If the arbiter clears pend[i] in the same cycle a new edge arrives, the new capture is taken and pend[i] stays set; this is not counted as lost.
- Arbiter/serialiser FSM:
  - States IDLE → W0 → W1 → W2 → IDLE.
  - In IDLE, selects the lowest-index pending channel, latches its capture and clears its pend.
  - Each W state writes one word, and holds while the FIFO is full.
  - W2 returns to IDLE, or goes directly to W0 if another channel is pending.
- Word format:
  - W0: {ID, 2'd0, 2'b00, EDGE, CH[2:0], ts[63:48], 4'b0000}
  - W1: {ID, 2'd1, 2'b00, ts[47:24]}
  - W2: {ID, 2'd2, 2'b00, ts[23:0]}
- FIFO:
  - A word written in cycle n is visible on FIFO_DATA in cycle n+1.
  - FIFO_READ while empty is ignored.
  - Simultaneous read and write with a full FIFO is allowed (count unchanged).

## Timing
- Reset values:
  - BUS_DATA_OUT=0, TIMESTAMP_OUT=0 (counter), FIFO_EMPTY=1, FIFO_DATA=0.
  - All pend flags clear, FSM in IDLE, LOST=0.
- Async assert of BUS_RST_N mid-event: the partial event is discarded, and no W1/W2 words follow after release.
- Bus reads: BUS_DATA_OUT is valid the cycle after BUS_RD. Writes take effect on the BUS_WR edge.
- Event latency with FIFO empty and FSM idle:
  - DI sampled at edge k; qualified edge detected in cycle k+2; ts holds TIMESTAMP_OUT of cycle k+2.
  - pend set at k+3. FSM in W0 at k+4, W0 written at k+5, FIFO_EMPTY low from k+5.
  - One word per cycle thereafter.
- Throughput: 1 event per 3 cycles sustained.
- DI pulses shorter than 2 cycles may be missed. A stable input generates no events.

## Test plan
- Reset, CONF=1, CH_EN=1, RISE=1; pulse DI[0] for 4 cycles. Expect 3 words: W0 ID=1, idx 0, EDGE=1, CH=0. ts equals the counter value 2 cycles after the sampling edge. FIFO_EMPTY low exactly 5 cycles after sampling. Pop 3 words, then FIFO_EMPTY=1.
- CH_EN=0xF, RISE=FALL=0xF; raise DI[3:0] together. Expect 4 events in channel order 0,1,2,3 with identical ts, all EDGE=1. Falling edges give EDGE=0.
- FIFO_DEPTH=4, FIFO_READ held 0; fire 5 events on ch0 spaced 10 cycles. Expect the FSM to stall in W1 of event 2; event 3 captured; events 4 and 5 lost. LOST=2. After draining, the remaining words arrive intact.
- USE_EXT=1, EXT_TIMESTAMP=64'hFFFF_FFFF_FFFF_FFFE; read addresses 8..15. Expect bytes FE,FF,FF,FF,FF,FF,FF,FF. Separately, force the counter near wrap and confirm an event captured after 2^64-1 shows ts=0.
- GATE=1, EXT_ENABLE=0; pulse DI[1]. Expect no words and LOST=0. Set EXT_ENABLE=1 and pulse again: one event is captured.
- Assert BUS_RST_N between W0 and W1, or write address 0 there. Expect FIFO_EMPTY=1 and LOST=0 with the counter restarted, and no stray W1/W2 words afterwards. CONF is preserved after the soft reset and cleared after the hard reset.
